// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package md_pkg;
  localparam int ITER = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_DIV   = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, DZERO} md_state_e;
endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The partial remainder is always below the divisor, so the next remainder fits WIDTH bits.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);
  logic [WIDTH:0] shf, diff;

  // shift in next dividend bit, subtract divisor, restore on borrow
  always_comb begin
    shf     = {rem, bit_in};
    diff    = shf - {1'b0, dvsr};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring) unit with HI/LO.
// Optional macro MD_UNSIGNED_EN enables multu/divu via MDcontrol[1].
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = md_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MDcontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             Div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import md_pkg::*;

  localparam int CW = $clog2(ITER);

  md_state_e        state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc_hi;   // Booth accumulator (one guard bit) / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier / dividend shifting into quotient
  logic             qm1;      // Booth q[-1]
  logic [WIDTH-1:0] b_r;      // multiplicand or divisor magnitude
  logic             op_div, op_uns, sa, sb;

  logic             uns_req;
`ifdef MD_UNSIGNED_EN
  logic [WIDTH-1:0] a_r;      // raw multiplicand kept for the unsigned high-word fixup
  assign uns_req = MDcontrol[1];
`else
  logic unused_uns;
  assign unused_uns = MDcontrol[1];
  assign uns_req    = 1'b0;
`endif

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mext, bsum;
  logic [WIDTH-1:0] rem_nxt, hi_fix, lo_fix;
  logic             qbit;

  // operand signs and magnitudes at capture time
  always_comb begin
    sgn_a = a[WIDTH-1] & ~uns_req;
    sgn_b = b[WIDTH-1] & ~uns_req;
    a_mag = sgn_a ? -a : a;
    b_mag = sgn_b ? -b : b;
  end

  // Booth add/subtract ahead of the arithmetic shift
  always_comb begin
    mext = {b_r[WIDTH-1], b_r};
    case ({acc_lo[0], qm1})
      2'b01:   bsum = acc_hi + mext;
      2'b10:   bsum = acc_hi - mext;
      default: bsum = acc_hi;
    endcase
  end

  md_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (acc_hi[WIDTH-1:0]),
    .bit_in  (acc_lo[WIDTH-1]),
    .dvsr    (b_r),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // final result: sign correction for div, high-word fixup for unsigned mult
  always_comb begin
    if (op_div) begin
      lo_fix = (sa ^ sb) ? -acc_lo : acc_lo;
      hi_fix = sa ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end else begin
      lo_fix = acc_lo;
      hi_fix = acc_hi[WIDTH-1:0];
`ifdef MD_UNSIGNED_EN
      if (op_uns)
        hi_fix = acc_hi[WIDTH-1:0] + (a_r[WIDTH-1] ? b_r : '0) + (b_r[WIDTH-1] ? a_r : '0);
`endif
    end
  end

  // control FSM with datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      qm1    <= 1'b0;
      b_r    <= '0;
      op_div <= 1'b0;
      op_uns <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MD_UNSIGNED_EN
      a_r    <= '0;
`endif
    end else begin
      done <= 1'b0;
      Div0 <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_div <= MDcontrol[0];
          op_uns <= uns_req;
          sa     <= MDcontrol[0] & sgn_a;
          sb     <= MDcontrol[0] & sgn_b;
          count  <= '0;
          qm1    <= 1'b0;
          acc_hi <= '0;
`ifdef MD_UNSIGNED_EN
          a_r    <= a;
`endif
          if (MDcontrol[0] && b == '0) begin
            state <= DZERO;
            done  <= 1'b1;
            Div0  <= 1'b1;
          end else begin
            state  <= CALC;
            busy   <= 1'b1;
            acc_lo <= MDcontrol[0] ? a_mag : a;
            b_r    <= MDcontrol[0] ? b_mag : b;
          end
        end
        CALC: begin
          if (op_div) begin
            acc_hi <= {1'b0, rem_nxt};
            acc_lo <= {acc_lo[WIDTH-2:0], qbit};
          end else begin
            acc_hi <= {bsum[WIDTH], bsum[WIDTH:1]};
            acc_lo <= {bsum[0], acc_lo[WIDTH-1:1]};
            qm1    <= acc_lo[0];
          end
          count <= count + 1'b1;
          if (count == CW'(ITER-1)) state <= FIX;
        end
        FIX: begin
          hi    <= hi_fix;
          lo    <= lo_fix;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        DZERO:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver queues expected results, monitor checks on done.
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  MDcontrol = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, Div0;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .MDcontrol(MDcontrol),
    .a(a), .b(b), .busy(busy), .done(done), .Div0(Div0), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          sedge;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare on every done pulse
  always @(posedge clock) begin
    #1;
    if (reset && done) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_hi"},   hi,   e.hi);
        chk({e.name, "_lo"},   lo,   e.lo);
        chk({e.name, "_div0"}, Div0, e.dz);
        chk({e.name, "_lat"},  cyc - e.sedge + 1, e.lat);
        chk({e.name, "_busy"}, busy, !e.dz);
      end
    end
  end

  task automatic pulse(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    MDcontrol = op;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    a = ~av;            // operands must be ignored after capture
    b = ~bv;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clock); #2;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: pending=%0d required=0", nm, q.size());
      q.delete();
    end
    @(posedge clock); #2;
  endtask

  task automatic run(input string nm, input logic [1:0] op, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz, input int elat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.sedge = cyc + 1; e.name = nm;
    q.push_back(e);
    pulse(op, av, bv);
    wait_drain(nm);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_div0", Div0, 1'b0);
    chk("rst_hi",   hi,   32'h0);
    chk("rst_lo",   lo,   32'h0);
    reset = 1'b1;
    @(posedge clock); #2;

    run("mul_7xm3",   MD_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run("mul_minsq",  MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
    run("mul_m1m1",   MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34);
    run("div_m7d2",   MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run("div_ovf",    MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    run("div_7dm2",   MD_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
    run("div_5d2",    MD_DIV,  32'd5,        32'd2,        32'h00000001, 32'h00000002, 1'b0, 34);
    run("div_zero",   MD_DIV,  32'd5,        32'd0,        32'h00000001, 32'h00000002, 1'b1, 1);

    // start pulse while busy is ignored
    e.hi = 32'h0; e.lo = 32'd12; e.dz = 1'b0; e.lat = 34; e.sedge = cyc + 1; e.name = "mul_repulse";
    q.push_back(e);
    pulse(MD_MULT, 32'd3, 32'd4);
    repeat (4) @(posedge clock);
    #2;
    pulse(MD_MULT, 32'd9, 32'd4);
    wait_drain("mul_repulse");

`ifdef MD_UNSIGNED_EN
    run("divu",  MD_DIVU,  32'hFFFFFFFF, 32'd2, 32'h00000001, 32'h7FFFFFFF, 1'b0, 34);
    run("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34);
`else
    run("divu_off",  MD_DIVU,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34);
    run("multu_off", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
`endif

    // reset mid-operation aborts without a done pulse
    pulse(MD_MULT, 32'd5, 32'd6);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock); #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi",   hi,   32'h0);
    chk("midrst_lo",   lo,   32'h0);
    reset = 1'b1;
    repeat (45) @(posedge clock);
    #2;
    chk("midrst_hold_hi", hi, 32'h0);
    chk("midrst_hold_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit sitting directly downstream of the multicycle control FSM.
- Control raises start with MDcontrol selecting the operation and waits for done; register operands A/B come from the register-file output latches.
- Results go to dedicated HI/LO registers inside this block, readable by mfhi/mflo paths.
- Division by zero raises div0, which control uses for its exception path.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- ITER, 32, compute iterations per operation (must equal WIDTH).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request pulse from control
- MDcontrol  in  2  op select: bit0 0=mult 1=div; bit1 unsigned select (see Optional Feature)
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse
- Div0  out  1  one-cycle divide-by-zero pulse, coincident with done
- hi  out  WIDTH  HI register (product high word / remainder)
- lo  out  WIDTH  LO register (product low word / quotient)

Behaviour:
- Interface is fixed: one clock named clock; reset named reset, synchronous, active-low.
- Reset (reset==0 at a rising edge): state=IDLE; busy=0, done=0, Div0=0, hi=0, lo=0; internal counters and accumulators cleared. Reset mid-operation aborts it, with no done pulse.
- States:
  - IDLE: start==1 → capture a, b, MDcontrol.
    - Div with b==0 → DZERO.
    - Otherwise → CALC with count=0.
    - start==0 → stay.
  - CALC: one Booth radix-2 step (mult) or one restoring-subtract step on magnitudes (div) per cycle; count++. At count==ITER-1 → FIX.
  - FIX: apply sign correction, write hi/lo → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - DZERO: done=1 and Div0=1 for one cycle; hi/lo unchanged → IDLE.
- Latency from the edge sampling start to the done-high cycle:
  - normal ops: ITER+2 edges (34);
  - divide by zero: 1 edge.
- busy=1 in CALC, FIX and DONE; busy=0 in IDLE and DZERO. start while busy is ignored, with no queueing.
- Mult: {hi,lo} = full signed 2·WIDTH-bit product, exact for all inputs, including -2^31 × -2^31.
- Div:
  - lo = quotient truncated toward zero.
  - hi = remainder carrying the dividend's sign.
  - -2^31 / -1 gives lo=0x80000000, hi=0, with no flag.
- hi/lo hold between operations and change only in FIX or on reset.
- Operands are sampled only at start; changes on a/b during CALC have no effect.

Optional Feature:
- Macro MD_UNSIGNED_EN.
- Defined: MDcontrol[1]=1 selects multu/divu. Operands are treated as unsigned, with no sign correction in FIX.
- Undefined: MDcontrol[1] is ignored and all operations are signed. Latency is identical in both builds.

Decomposition:
- Package md_pkg: op encodings (MD_MULT=2'b00, MD_DIV=2'b01, MD_MULTU=2'b10, MD_DIVU=2'b11), state enum (IDLE, CALC, FIX, DONE, DZERO), ITER constant.
- One sub-module, md_div_step: combinational single restoring-division iteration (partial remainder, divisor, quotient bit in → next remainder, quotient bit out). Booth step stays inline.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) → done exactly 34 edges after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, Div0=0.
- mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- After a result hi=1, lo=2: div a=5, b=0 → done and Div0 high one edge after start, busy never high, hi=1 and lo=2 unchanged.
- start mult 3×4, re-pulse start at cycle 5 with a=9 → result still hi=0, lo=12; separate run with reset=0 at cycle 10 of a mult → busy=0, hi=lo=0, no done pulse.
- With MD_UNSIGNED_EN: MDcontrol=2'b11, a=0xFFFFFFFF, b=2 → lo=0x7FFFFFFF, hi=1. Without the macro, the same stimulus → lo=0, hi=0xFFFFFFFF.
